// File: rtl/dart_sim9_lite_pkg.sv
// ============================================================================
// Module      : dart_sim9_lite_pkg
// Description : Shared constants, flit type, config-word field offsets and
//               small arithmetic helpers for the 9-node traffic simulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dart_sim9_lite_pkg;

    localparam int NNODES   = 9;
    localparam int TS_WIDTH = 10;
    localparam int QDEPTH   = 4;
    localparam int CFG_W    = 16;
    localparam int STAT_W   = 16;

    // Config word layout; bits [10:8] are reserved.
    localparam int CFG_INJ_EN  = 15;
    localparam int CFG_DEST_HI = 14;
    localparam int CFG_DEST_LO = 11;
    localparam int CFG_PER_HI  = 7;
    localparam int CFG_PER_LO  = 0;

    typedef struct packed {
        logic [3:0]          dest;
        logic [TS_WIDTH-1:0] ts;
    } flit_t;

    // Saturating add for the 16-bit stats counters.
    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [STAT_W-1:0] b);
        logic [STAT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[STAT_W] ? {STAT_W{1'b1}} : s[STAT_W-1:0];
    endfunction

    // (base + off) mod NNODES for base, off in 0..NNODES-1, kept in 4 bits.
    function automatic logic [3:0] rr_idx(input logic [3:0] base,
                                          input logic [3:0] off);
        logic [3:0] rem;
        rem = 4'(NNODES) - base;
        if (off >= rem) begin
            return off - rem;
        end
        return base + off;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dart_sim9_lite_sim_node.sv
// ============================================================================
// Module      : dart_sim9_lite_sim_node
// Description : One simulator node: config register (one link of the config
//               chain), injection countdown, 4-entry injection queue and
//               three saturating stats counters (three links of the stats
//               chain).
// Ports       : clock/reset      - clock, async active-low reset
//               step_i           - simulation step this cycle
//               inj_allow_i      - injections permitted (not stopped)
//               measure_i        - stats counting enabled
//               stats_shift_i    - advance stats chain (blocks counting)
//               cfg_shift_i      - advance config chain
//               cfg_i / cfg_o    - config chain in / this node's word
//               sim_time_i       - current step number (flit timestamp)
//               pop_i            - crossbar granted this node's head
//               rx_inc_i         - a flit was delivered to this node
//               lat_i            - latency of that delivered flit
//               stats_i/stats_o  - stats chain in (from next node) / head
//               head_o, empty_o  - queue head flit and empty flag
//               err_o            - injection dropped this step
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dart_sim9_lite_sim_node
    import dart_sim9_lite_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                step_i,
    input  logic                inj_allow_i,
    input  logic                measure_i,
    input  logic                stats_shift_i,
    input  logic                cfg_shift_i,
    input  logic [CFG_W-1:0]    cfg_i,
    output logic [CFG_W-1:0]    cfg_o,
    input  logic [TS_WIDTH-1:0] sim_time_i,
    input  logic                pop_i,
    input  logic                rx_inc_i,
    input  logic [TS_WIDTH-1:0] lat_i,
    input  logic [STAT_W-1:0]   stats_i,
    output logic [STAT_W-1:0]   stats_o,
    output flit_t               head_o,
    output logic                empty_o,
    output logic                err_o
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int OCC_W = $clog2(QDEPTH + 1);

    logic [CFG_W-1:0]  cfg_q;
    logic [7:0]        cd_q;
    flit_t             fifo_q [QDEPTH];
    logic [PTR_W-1:0]  wr_q;
    logic [PTR_W-1:0]  rd_q;
    logic [OCC_W-1:0]  occ_q;
    logic [STAT_W-1:0] inj_q;
    logic [STAT_W-1:0] rx_q;
    logic [STAT_W-1:0] lat_q;

    logic              inj_en;
    logic [3:0]        dest;
    logic [7:0]        period;
    logic              gen_active;
    logic              fire;
    logic              bad_dest;
    logic              full;
    logic              push;
    logic              pop;
    flit_t             new_flit;

    assign inj_en     = cfg_q[CFG_INJ_EN];
    assign dest       = cfg_q[CFG_DEST_HI:CFG_DEST_LO];
    assign period     = cfg_q[CFG_PER_HI:CFG_PER_LO];

    // Countdown runs only on steps where injection is enabled and allowed;
    // stop_injection freezes it.
    assign gen_active = step_i & inj_allow_i & inj_en;
    assign fire       = gen_active & (cd_q == 8'd0);
    assign bad_dest   = dest > 4'(NNODES - 1);
    // Fullness is judged before any same-step pop, so a full queue drops.
    assign full       = occ_q == OCC_W'(QDEPTH);
    assign push       = fire & ~bad_dest & ~full;
    assign pop        = step_i & pop_i & (occ_q != '0);

    assign new_flit.dest = dest;
    assign new_flit.ts   = sim_time_i;

    assign cfg_o   = cfg_q;
    assign stats_o = inj_q;
    assign head_o  = fifo_q[rd_q];
    assign empty_o = occ_q == '0;
    assign err_o   = fire & (bad_dest | full);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cfg_q <= '0;
            cd_q  <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
            inj_q <= '0;
            rx_q  <= '0;
            lat_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (cfg_shift_i) begin
                cfg_q <= cfg_i;
            end
            if (gen_active) begin
                cd_q <= (cd_q == 8'd0) ? period : cd_q - 8'd1;
            end
            if (push) begin
                fifo_q[wr_q] <= new_flit;
                wr_q         <= wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);

            // The counters double as the stats chain; a shift has priority
            // and suppresses counting for that cycle.
            if (stats_shift_i) begin
                inj_q <= rx_q;
                rx_q  <= lat_q;
                lat_q <= stats_i;
            end else if (measure_i) begin
                if (push) begin
                    inj_q <= sat_add(inj_q, STAT_W'(1));
                end
                if (rx_inc_i) begin
                    rx_q  <= sat_add(rx_q, STAT_W'(1));
                    lat_q <= sat_add(lat_q, STAT_W'(lat_i));
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dart_sim9_lite.sv
// ============================================================================
// Module      : dart_sim9_lite
// Description : Cycle-stepped 9-node network traffic simulator. Nine sim
//               nodes feed a round-robin 9x9 crossbar; config and stats are
//               accessed through shift chains.
// Ports       : clock, reset (async active-low)
//               enable, stop_injection, measure - simulation controls
//               sim_time_tick, sim_time, error, quiescent - status
//               config_in/_valid, config_out/_valid - config chain
//               stats_out, stats_shift - stats chain readout
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dart_sim9_lite
    import dart_sim9_lite_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                stop_injection,
    input  logic                measure,
    output logic                sim_time_tick,
    output logic [TS_WIDTH-1:0] sim_time,
    output logic                error,
    output logic                quiescent,
    input  logic [CFG_W-1:0]    config_in,
    input  logic                config_in_valid,
    output logic [CFG_W-1:0]    config_out,
    output logic                config_out_valid,
    output logic [STAT_W-1:0]   stats_out,
    input  logic                stats_shift
);

    logic [TS_WIDTH-1:0] sim_time_q;
    logic                tick_q;
    logic                error_q;
    logic [CFG_W-1:0]    cfg_out_q;
    logic                cfg_out_valid_q;
    logic [3:0]          ptr_q [NNODES];

    logic [CFG_W-1:0]    cfg_link   [NNODES+1];
    logic [STAT_W-1:0]   stats_link [NNODES+1];
    flit_t               head [NNODES];
    logic [NNODES-1:0]   empty;
    logic [NNODES-1:0]   node_err;
    logic [NNODES-1:0]   pop;
    logic [NNODES-1:0]   rx_inc;
    logic [TS_WIDTH-1:0] lat [NNODES];

    logic [NNODES-1:0]   req [NNODES];   // req[d][s]: head of s targets d
    logic [NNODES-1:0]   dlv;            // destination d receives this step
    logic [3:0]          win [NNODES];   // winning source for destination d
    logic [3:0]          arb_idx;

    assign cfg_link[0]          = config_in;
    assign stats_link[NNODES]   = '0;

    genvar i;
    generate
        for (i = 0; i < NNODES; i++) begin : g_node
            dart_sim9_lite_sim_node u_node (
                .clock         (clock),
                .reset         (reset),
                .step_i        (enable),
                .inj_allow_i   (~stop_injection),
                .measure_i     (measure),
                .stats_shift_i (stats_shift),
                .cfg_shift_i   (config_in_valid),
                .cfg_i         (cfg_link[i]),
                .cfg_o         (cfg_link[i+1]),
                .sim_time_i    (sim_time_q),
                .pop_i         (pop[i]),
                .rx_inc_i      (rx_inc[i]),
                .lat_i         (lat[i]),
                .stats_i       (stats_link[i+1]),
                .stats_o       (stats_link[i]),
                .head_o        (head[i]),
                .empty_o       (empty[i]),
                .err_o         (node_err[i])
            );
        end
    endgenerate

    // Crossbar: one round-robin arbiter per destination. A source's head has
    // a single destination, so each source wins at most one arbiter and no
    // extra per-source arbitration is needed.
    always_comb begin
        arb_idx = '0;
        for (int d = 0; d < NNODES; d++) begin
            dlv[d] = 1'b0;
            win[d] = '0;
            for (int s = 0; s < NNODES; s++) begin
                req[d][s] = ~empty[s] && (head[s].dest == 4'(d));
            end
            for (int k = 0; k < NNODES; k++) begin
                arb_idx = rr_idx(ptr_q[d], 4'(k));
                if (!dlv[d] && req[d][arb_idx]) begin
                    dlv[d] = 1'b1;
                    win[d] = arb_idx;
                end
            end
            rx_inc[d] = enable & dlv[d];
            lat[d]    = sim_time_q - head[win[d]].ts;
        end
        for (int s = 0; s < NNODES; s++) begin
            pop[s] = 1'b0;
            for (int d = 0; d < NNODES; d++) begin
                if (dlv[d] && (win[d] == 4'(s))) begin
                    pop[s] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sim_time_q      <= '0;
            tick_q          <= 1'b0;
            error_q         <= 1'b0;
            cfg_out_q       <= '0;
            cfg_out_valid_q <= 1'b0;
            for (int d = 0; d < NNODES; d++) begin
                ptr_q[d] <= '0;
            end
        end else begin
            tick_q          <= enable;
            cfg_out_valid_q <= config_in_valid;
            error_q         <= error_q | (|node_err);
            if (enable) begin
                sim_time_q <= sim_time_q + TS_WIDTH'(1);
                for (int d = 0; d < NNODES; d++) begin
                    if (dlv[d]) begin
                        ptr_q[d] <= (win[d] == 4'(NNODES - 1)) ? 4'd0 : win[d] + 4'd1;
                    end
                end
            end
            if (config_in_valid) begin
                cfg_out_q <= cfg_link[NNODES];
            end
        end
    end

    assign sim_time         = sim_time_q;
    assign sim_time_tick    = tick_q;
    assign error            = error_q;
    assign quiescent        = &empty;
    assign config_out       = cfg_out_q;
    assign config_out_valid = cfg_out_valid_q;
    assign stats_out        = stats_link[0];

endmodule

`default_nettype wire

// File: tb/tb_dart_sim9_lite.sv
// ============================================================================
// Module      : tb_dart_sim9_lite
// Description : Self-checking bench for dart_sim9_lite: directed scenarios
//               plus a randomized phase, all checked every cycle against a
//               queue-based behavioural model of the simulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dart_sim9_lite;
    import dart_sim9_lite_pkg::*;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                enable = 1'b0;
    logic                stop_injection = 1'b0;
    logic                measure = 1'b0;
    logic                sim_time_tick;
    logic [TS_WIDTH-1:0] sim_time;
    logic                error;
    logic                quiescent;
    logic [15:0]         config_in = '0;
    logic                config_in_valid = 1'b0;
    logic [15:0]         config_out;
    logic                config_out_valid;
    logic [15:0]         stats_out;
    logic                stats_shift = 1'b0;

    always #5 clock = ~clock;

    dart_sim9_lite dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .stop_injection   (stop_injection),
        .measure          (measure),
        .sim_time_tick    (sim_time_tick),
        .sim_time         (sim_time),
        .error            (error),
        .quiescent        (quiescent),
        .config_in        (config_in),
        .config_in_valid  (config_in_valid),
        .config_out       (config_out),
        .config_out_valid (config_out_valid),
        .stats_out        (stats_out),
        .stats_shift      (stats_shift)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model. Flits are stored as dest*1024 + timestamp.
    int mq [NNODES][$];
    int m_cfg [NNODES];
    int m_cd  [NNODES];
    int m_ptr [NNODES];
    int m_st  [27];
    int m_time;
    int m_tick;
    int m_err;
    int m_cfg_out;
    int m_cfg_out_v;

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NNODES; n++) begin
            mq[n].delete();
            m_cfg[n] = 0;
            m_cd[n]  = 0;
            m_ptr[n] = 0;
        end
        for (int k = 0; k < 27; k++) m_st[k] = 0;
        m_time = 0; m_tick = 0; m_err = 0; m_cfg_out = 0; m_cfg_out_v = 0;
    endtask

    // One clock edge of the simulator, evaluated from the pre-edge state.
    task automatic model_clock();
        int win [NNODES];
        int sz  [NNODES];
        int pushok [NNODES];
        int f, lat, dst;
        if (enable) begin
            for (int s = 0; s < NNODES; s++) sz[s] = mq[s].size();
            for (int d = 0; d < NNODES; d++) begin
                win[d] = -1;
                for (int k = 0; k < NNODES; k++) begin
                    int s;
                    s = (m_ptr[d] + k) % NNODES;
                    if (win[d] < 0 && sz[s] > 0 && (mq[s][0] / 1024) == d) win[d] = s;
                end
            end
            for (int n = 0; n < NNODES; n++) begin
                pushok[n] = 0;
                if (((m_cfg[n] >> 15) & 1) == 1 && !stop_injection) begin
                    if (m_cd[n] == 0) begin
                        dst = (m_cfg[n] >> 11) & 15;
                        if (dst > 8 || sz[n] == QDEPTH) m_err = 1;
                        else pushok[n] = 1;
                        m_cd[n] = m_cfg[n] & 255;
                    end else begin
                        m_cd[n] = m_cd[n] - 1;
                    end
                end
            end
            for (int d = 0; d < NNODES; d++) begin
                if (win[d] >= 0) begin
                    f   = mq[win[d]].pop_front();
                    lat = (m_time - (f % 1024)) & 1023;
                    if (measure && !stats_shift) begin
                        m_st[3*d+1] = sat16(m_st[3*d+1] + 1);
                        m_st[3*d+2] = sat16(m_st[3*d+2] + lat);
                    end
                    m_ptr[d] = (win[d] + 1) % NNODES;
                end
            end
            for (int n = 0; n < NNODES; n++) begin
                if (pushok[n] == 1) begin
                    dst = (m_cfg[n] >> 11) & 15;
                    mq[n].push_back(dst * 1024 + m_time);
                    if (measure && !stats_shift) m_st[3*n] = sat16(m_st[3*n] + 1);
                end
            end
            m_time = (m_time + 1) % 1024;
        end
        m_tick = enable ? 1 : 0;
        if (stats_shift) begin
            for (int k = 0; k < 26; k++) m_st[k] = m_st[k+1];
            m_st[26] = 0;
        end
        if (config_in_valid) begin
            m_cfg_out = m_cfg[8];
            for (int n = 8; n > 0; n--) m_cfg[n] = m_cfg[n-1];
            m_cfg[0] = int'(config_in);
        end
        m_cfg_out_v = config_in_valid ? 1 : 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_quiet();
        for (int n = 0; n < NNODES; n++) if (mq[n].size() != 0) return 0;
        return 1;
    endfunction

    task automatic check_all();
        chk("sim_time", 32'(sim_time), m_time);
        chk("tick", 32'(sim_time_tick), m_tick);
        chk("error", 32'(error), m_err);
        chk("quiescent", 32'(quiescent), model_quiet());
        chk("config_out", 32'(config_out), m_cfg_out);
        chk("config_out_valid", 32'(config_out_valid), m_cfg_out_v);
        chk("stats_out", 32'(stats_out), m_st[0]);
    endtask

    task automatic cyc(input bit en, input bit stp, input bit meas,
                       input bit cv, input logic [15:0] cin, input bit ss);
        enable = en; stop_injection = stp; measure = meas;
        config_in_valid = cv; config_in = cin; stats_shift = ss;
        @(posedge clock);
        model_clock();
        #1;
        check_all();
    endtask

    // Asserts reset between edges, checks the cleared state, releases it.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clock);
        reset = 1'b1;
    endtask

    // w[n] is the word for node n; node 8 must be written first.
    task automatic load_cfg(input int w [NNODES]);
        for (int n = NNODES - 1; n >= 0; n--) cyc(0, 0, 0, 1, 16'(w[n]), 0);
    endtask

    task automatic readout(output int words [27]);
        for (int k = 0; k < 27; k++) begin
            words[k] = int'(stats_out);
            cyc(0, 0, 0, 0, 16'h0, 1);
        end
    endtask

    initial begin
        int w [NNODES];
        int words [27];

        // Reset state
        model_reset();
        #3;
        check_all();
        @(negedge clock);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 16'h0, 0);
        chk("reset_quiescent", 32'(quiescent), 1);

        // Config loopback: 18 shifts, first nine words return on shifts 10..18
        for (int k = 1; k <= 18; k++) begin
            cyc(0, 0, 0, 1, 16'(k), 0);
            if (k >= 10) chk("loopback_word", 32'(config_out), k - 9);
            chk("loopback_valid", 32'(config_out_valid), 1);
        end
        cyc(0, 0, 0, 0, 16'h0, 0);
        chk("loopback_valid_drop", 32'(config_out_valid), 0);

        // Node0 -> node1 every step for 10 steps
        do_reset();
        for (int n = 0; n < NNODES; n++) w[n] = 0;
        w[0] = 32'h8800;
        load_cfg(w);
        for (int k = 0; k < 10; k++) cyc(1, 0, 1, 0, 16'h0, 0);
        for (int k = 0; k < 3; k++)  cyc(1, 1, 1, 0, 16'h0, 0);
        chk("drained_quiescent", 32'(quiescent), 1);
        readout(words);
        chk("node0_inj", words[0], 10);
        chk("node1_inj", words[3], 0);
        chk("node1_rx", words[4], 10);
        chk("node1_lat", words[5], 10);

        // Nodes 0 and 2 both to node4: contention, overflow, then mid-run reset
        do_reset();
        for (int n = 0; n < NNODES; n++) w[n] = 0;
        w[0] = 32'hA000;
        w[2] = 32'hA000;
        load_cfg(w);
        for (int k = 0; k < 12; k++) cyc(1, 0, 1, 0, 16'h0, 0);
        chk("hotspot_error", 32'(error), 1);
        chk("hotspot_busy", 32'(quiescent), 0);
        readout(words);
        chk("node4_rx", words[13], 11);
        cyc(1, 0, 1, 0, 16'h0, 0);
        cyc(1, 0, 1, 0, 16'h0, 0);
        do_reset();
        chk("midrst_time", 32'(sim_time), 0);
        chk("midrst_error", 32'(error), 0);
        chk("midrst_quiescent", 32'(quiescent), 1);
        cyc(0, 0, 0, 0, 16'h0, 0);
        chk("post_rst_quiescent", 32'(quiescent), 1);

        // Illegal destination 12
        for (int n = 0; n < NNODES; n++) w[n] = 0;
        w[3] = 32'hE002;
        load_cfg(w);
        chk("pre_baddest_error", 32'(error), 0);
        for (int k = 0; k < 10; k++) cyc(1, 0, 1, 0, 16'h0, 0);
        chk("baddest_error", 32'(error), 1);
        readout(words);
        chk("baddest_inj", words[9], 0);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < NNODES; n++) begin
            int dst;
            dst  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
            w[n] = (($urandom_range(0, 3) != 0) ? 32'h8000 : 0) | (dst << 11) | int'($urandom_range(0, 6));
        end
        load_cfg(w);
        for (int k = 0; k < 300; k++) begin
            bit cv;
            cv = ($urandom_range(0, 19) == 0);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 4) != 0,
                cv, cv ? 16'($urandom_range(0, 65535)) : 16'h0, $urandom_range(0, 15) == 0);
        end
        for (int k = 0; k < 20; k++) cyc(1, 1, 1, 0, 16'h0, 0);
        readout(words);

        // sim_time wrap
        do_reset();
        for (int k = 0; k < 1024; k++) cyc(1, 0, 0, 0, 16'h0, 0);
        chk("wrap_time", 32'(sim_time), 0);
        chk("wrap_tick", 32'(sim_time_tick), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
